osd_console_writer: RTL

- Character-stream front end for the OSD text overlay.
- Accepts ASCII bytes over a valid/ready handshake and keeps a text cursor.
- Drives the tile-RAM write port (xt, yt, ch_in, we_ch) of the OSD source, so the processor never computes tile addresses.
- Interprets a small set of control codes: newline, carriage return, backspace, form feed.
- Performs line and screen clears by burst-writing the null (transparent) character.

---
 rtl/osd_console_writer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/osd_console_writer.sv
// rtl/osd_console_writer.sv - OSD console writer: byte stream to tile-RAM writes with cursor and clears.
// Optional OSD_LINE_CLEAR_EN: clear the entered row on wrap/newline.
module osd_console_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_valid,
  input  logic [7:0] wr_char,
  input  logic       wr_rev,
  output logic       wr_ready,
  output logic [6:0] xt,
  output logic [4:0] yt,
  output logic [7:0] ch_out,
  output logic       we_ch,
  output logic [6:0] cur_x,
  output logic [4:0] cur_y,
  output logic       busy
);

  localparam logic [6:0] LAST_X = 7'(COLS - 1);
  localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

`ifdef OSD_LINE_CLEAR_EN
  typedef enum logic [1:0] {S_CLR_SCREEN, S_CLR_LINE, S_IDLE} state_t;
`else
  typedef enum logic [1:0] {S_CLR_SCREEN, S_IDLE} state_t;
`endif

  state_t     r_state, w_state_nx;
  logic [6:0] r_cur_x, w_cur_x_nx;
  logic [4:0] r_cur_y, w_cur_y_nx;
  logic [6:0] r_clr_x, w_clr_x_nx;
  logic [4:0] r_clr_y, w_clr_y_nx;
  logic       r_clr_done, w_clr_done_nx;
  logic [6:0] r_xt, w_xt_nx;
  logic [4:0] r_yt, w_yt_nx;
  logic [7:0] r_ch, w_ch_nx;
  logic       r_we, w_we_nx;
  logic       w_row_enter;
  logic [6:0] w_code;
  logic       w_unused;

  assign w_code   = wr_char[6:0];
  assign w_unused = wr_char[7];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_CLR_SCREEN;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_clr_x    <= '0;
      r_clr_y    <= '0;
      r_clr_done <= 1'b0;
      r_xt       <= '0;
      r_yt       <= '0;
      r_ch       <= '0;
      r_we       <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cur_x    <= w_cur_x_nx;
      r_cur_y    <= w_cur_y_nx;
      r_clr_x    <= w_clr_x_nx;
      r_clr_y    <= w_clr_y_nx;
      r_clr_done <= w_clr_done_nx;
      r_xt       <= w_xt_nx;
      r_yt       <= w_yt_nx;
      r_ch       <= w_ch_nx;
      r_we       <= w_we_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_cur_x_nx    = r_cur_x;
    w_cur_y_nx    = r_cur_y;
    w_clr_x_nx    = r_clr_x;
    w_clr_y_nx    = r_clr_y;
    w_clr_done_nx = r_clr_done;
    w_xt_nx       = r_xt;
    w_yt_nx       = r_yt;
    w_ch_nx       = r_ch;
    w_we_nx       = 1'b0;
    w_row_enter   = 1'b0;

    case (r_state)
      S_CLR_SCREEN: begin
        // The done flag costs one idle cycle so ready rises after the last write is seen.
        if (r_clr_done) begin
          w_state_nx = S_IDLE;
          w_cur_x_nx = '0;
          w_cur_y_nx = '0;
        end else begin
          w_we_nx = 1'b1;
          w_xt_nx = r_clr_x;
          w_yt_nx = r_clr_y;
          w_ch_nx = 8'h00;
          if (r_clr_x == LAST_X) begin
            w_clr_x_nx = '0;
            if (r_clr_y == LAST_Y) w_clr_done_nx = 1'b1;
            else                   w_clr_y_nx    = r_clr_y + 5'd1;
          end else begin
            w_clr_x_nx = r_clr_x + 7'd1;
          end
        end
      end
`ifdef OSD_LINE_CLEAR_EN
      S_CLR_LINE: begin
        if (r_clr_done) begin
          w_state_nx = S_IDLE;
        end else begin
          w_we_nx = 1'b1;
          w_xt_nx = r_clr_x;
          w_yt_nx = r_cur_y;
          w_ch_nx = 8'h00;
          if (r_clr_x == LAST_X) w_clr_done_nx = 1'b1;
          else                   w_clr_x_nx    = r_clr_x + 7'd1;
        end
      end
`endif
      S_IDLE: begin
        if (wr_valid) begin
          if (w_code >= 7'h20 && w_code <= 7'h7E) begin
            w_we_nx = 1'b1;
            w_xt_nx = r_cur_x;
            w_yt_nx = r_cur_y;
            w_ch_nx = {wr_rev, w_code};
            if (r_cur_x == LAST_X) w_row_enter = 1'b1;
            else                   w_cur_x_nx  = r_cur_x + 7'd1;
          end else begin
            case (w_code)
              7'h0A: w_row_enter = 1'b1;
              7'h0D: w_cur_x_nx  = '0;
              7'h08: begin
                if (r_cur_x != 7'd0) begin
                  w_cur_x_nx = r_cur_x - 7'd1;
                  w_we_nx    = 1'b1;
                  w_xt_nx    = r_cur_x - 7'd1;
                  w_yt_nx    = r_cur_y;
                  w_ch_nx    = 8'h00;
                end
              end
              7'h0C: begin
                w_state_nx    = S_CLR_SCREEN;
                w_cur_x_nx    = '0;
                w_cur_y_nx    = '0;
                w_clr_x_nx    = '0;
                w_clr_y_nx    = '0;
                w_clr_done_nx = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
      default: w_state_nx = S_CLR_SCREEN;
    endcase

    // Row entry: no scrolling, the cursor wraps to row 0 after the last row.
    if (w_row_enter) begin
      w_cur_x_nx = '0;
      w_cur_y_nx = (r_cur_y == LAST_Y) ? 5'd0 : r_cur_y + 5'd1;
`ifdef OSD_LINE_CLEAR_EN
      w_state_nx    = S_CLR_LINE;
      w_clr_x_nx    = '0;
      w_clr_done_nx = 1'b0;
`endif
    end
  end

  assign wr_ready = (r_state == S_IDLE);
  assign busy     = ~wr_ready;
  assign xt       = r_xt;
  assign yt       = r_yt;
  assign ch_out   = r_ch;
  assign we_ch    = r_we;
  assign cur_x    = r_cur_x;
  assign cur_y    = r_cur_y;

endmodule
